divider: RTL and testbench
==========================

Name: divider

Overview:
- Multicycle signed 32-bit integer divider; the inverse operation of the existing iterative multiplier.
- Instantiated beside the multiplier inside the multdiv wrapper, driven by the same `ctrl_DIV` pulse / `data_resultRDY` handshake.
- Computes `data_operandA / data_operandB` by radix-2 restoring division on magnitudes, followed by a sign fix.
- Quotient truncates toward zero. Remainder is discarded.

Parameters:
- WIDTH, 32, operand and result width in bits
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clock  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- data_operandA  input  WIDTH  dividend, two's complement; sampled only on the ctrl_DIV edge
- data_operandB  input  WIDTH  divisor, two's complement; sampled only on the ctrl_DIV edge
- ctrl_DIV  input  1  start pulse, one cycle wide
- data_result  output  WIDTH  quotient
- data_exception  output  1  divide-by-zero flag, qualified by data_resultRDY
- data_resultRDY  output  1  one-cycle pulse: result and exception are valid

Behaviour:
- Reset: reset_n low forces, asynchronously:
  - state IDLE, counter 0
  - data_result 0, data_exception 0, data_resultRDY 0
  - all internal registers 0
- Reset mid-operation aborts the operation. No RDY pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with ctrl_DIV=1 (edge E0), latch |A|, |B|, sign = A[31]^B[31], and zero flag = (B==0).
  - Clear remainder register R (WIDTH+1 bits) and counter; go to RUN.
- RUN: each edge performs one iteration:
  - Shift {R,Q} left 1, moving the next dividend MSB into R.
  - Trial = R - {0,|B|}.
  - If trial is non-negative: R = trial, Q[0]=1. Otherwise R is restored and Q[0]=0.
  - Counter increments. After WIDTH iterations (edge E32) go to DONE.
- DONE, entered at E32:
  - data_resultRDY=1 for exactly the cycle after E32.
  - data_result = sign ? -Q : Q.
  - data_exception = zero flag.
  - Next edge returns to IDLE with RDY=0.
- Fixed latency: RDY is sampled high at edge E0+33, for every operand pair including B=0.
- Divide by zero: data_result=0, data_exception=1, same latency.
- Overflow: 0x80000000 / 0xFFFFFFFF gives data_result=0x80000000 (wraps) with data_exception=0.
- |A| of 0x80000000 is handled as unsigned 0x80000000; no intermediate overflow.
- Output hold:
  - data_result and data_exception hold their value after RDY falls, until the next completion.
  - Both are cleared to 0 on the edge accepting a new ctrl_DIV.
- ctrl_DIV while in RUN or DONE: aborts the current operation, re-latches the operands, restarts at iteration 0. The aborted operation produces no RDY pulse.
- ctrl_DIV simultaneous with DONE: the RDY pulse for the old result still occurs in that cycle (it is an output), and the new operation starts on the same edge.
- Operand inputs are ignored outside the ctrl_DIV edge.
- No combinational path from any input to any output.

Decomposition:
- Package `div_pkg`:
  - state enum (IDLE, RUN, DONE)
  - WIDTH default constant
  - CNT_W constant
  - localparam for the last-iteration count (WIDTH-1)
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: R, dividend MSB, |B|.
  - Outputs: next R, quotient bit.
  - Reusable for a future unrolled variant.
- Sign conversion (abs and negate) stays inline; a two's-complement negate is shared with the multiplier only through the package function `neg()`.

Test Plan:
- A=100, B=7, ctrl_DIV at E0 → RDY sampled high at E33 only; data_result=14, data_exception=0. RDY low at E32 and E34.
- A=-100 (0xFFFFFF9C), B=7 → data_result=0xFFFFFFF2 (-14). Also check A=100, B=-7 → 0xFFFFFFF2, and A=-100, B=-7 → 14.
- A=7, B=0 → RDY at E33, data_exception=1, data_result=0. Follow immediately with A=9, B=3 → exception cleared, result 3.
- A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 0. A=0x80000000, B=2 → 0xC0000000.
- Restart: start A=1000, B=10, then at E10 pulse ctrl_DIV with A=50, B=5 → no RDY at the original E33; RDY at E10+33 with result 10.
- Reset: start A=1000, B=10, drop reset_n for half a cycle at E15 → all outputs 0 immediately. No RDY at E33. A subsequent A=9, B=4 returns 2.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider
package div_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int WIDTH = 32;
   localparam int CNT_W = 6;
   localparam int LAST = WIDTH - 1;
   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic             msb,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   r_next,
   output logic             q_bit
);
   logic [WIDTH+1:0] trial;
   always_comb begin
      trial  = {r, msb} - {2'b00, b};
      q_bit  = ~trial[WIDTH+1];
      r_next = q_bit ? trial[WIDTH:0] : {r[WIDTH-1:0], msb};
   end
endmodule

// File: rtl/divider.sv
// divider: multicycle signed divider, magnitude restoring division then sign fix
module divider
   import div_pkg::*;
#(
   parameter int WIDTH = div_pkg::WIDTH,
   parameter int CNT_W = div_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   r, r_n;
   logic [WIDTH-1:0] q, b_abs, q_fin;
   logic             sign, zero, q_bit, last;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r(r), .msb(q[WIDTH-1]), .b(b_abs), .r_next(r_n), .q_bit(q_bit)
   );

   // a new start pulse always wins, aborting any operation in flight
   always_comb begin
      last    = state == RUN && cnt == CNT_W'(LAST);
      q_fin   = {q[WIDTH-2:0], q_bit};
      state_n = ctrl_DIV ? RUN : last ? DONE : state == DONE ? IDLE : state;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= '0;
         r              <= '0;
         q              <= '0;
         b_abs          <= '0;
         sign           <= 1'b0;
         zero           <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         state          <= state_n;
         data_resultRDY <= 1'b0;
         if (ctrl_DIV) begin
            q              <= data_operandA[WIDTH-1] ? neg(data_operandA) : data_operandA;
            b_abs          <= data_operandB[WIDTH-1] ? neg(data_operandB) : data_operandB;
            sign           <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            zero           <= data_operandB == '0;
            r              <= '0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
         end else if (state == RUN) begin
            r   <= r_n;
            q   <= q_fin;
            cnt <= cnt + 1'b1;
            if (last) begin
               data_result    <= zero ? '0 : sign ? neg(q_fin) : q_fin;
               data_exception <= zero;
               data_resultRDY <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench; stimulus queues expectations, monitor checks each RDY pulse
module tb_divider;
   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];

   divider dut (
      .clock(clock), .reset_n(reset_n), .data_operandA(data_operandA),
      .data_operandB(data_operandB), .ctrl_DIV(ctrl_DIV), .data_result(data_result),
      .data_exception(data_exception), .data_resultRDY(data_resultRDY)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // RDY is sampled on the falling edge so the pulse after the 33rd edge lands on cyc E0+33
   always @(negedge clock) begin
      if (reset_n && data_resultRDY) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rdy", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", data_result, e.res);
            check("exception", {31'b0, data_exception}, {31'b0, e.exc});
            check("rdy_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // called on a falling edge; ctrl_DIV is taken on the following rising edge
   task automatic start(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc);
      exp_t e;
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      e.res = res; e.exc = exc; e.cyc = cyc + 33;
      exp_q.push_back(e);
      @(negedge clock);
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clock);
      if (exp_q.size() != 0) begin
         check("timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      #2;
      check("reset_result", data_result, 32'd0);
      check("reset_exc", {31'b0, data_exception}, 32'd0);
      check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      start(32'd100, 32'd7, 32'd14, 1'b0);                  drain();
      start(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);     drain();
      start(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);   drain();
      start(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);    drain();

      // divide by zero, then a new start during the DONE cycle
      start(32'd7, 32'd0, 32'd0, 1'b1);
      repeat (32) @(negedge clock);
      start(32'd9, 32'd3, 32'd3, 1'b0);
      check("clear_on_start_exc", {31'b0, data_exception}, 32'd0);
      drain();

      start(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); drain();
      start(32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);         drain();

      // restart at E10 replaces the pending result
      start(32'd1000, 32'd10, 32'd100, 1'b0);
      repeat (9) @(negedge clock);
      void'(exp_q.pop_back());
      start(32'd50, 32'd5, 32'd10, 1'b0);
      check("clear_on_start_result", data_result, 32'd0);
      drain();

      // asynchronous reset in mid-operation
      start(32'd1000, 32'd10, 32'd100, 1'b0);
      repeat (14) @(negedge clock);
      #1 reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_reset_result", data_result, 32'd0);
      check("async_reset_exc", {31'b0, data_exception}, 32'd0);
      check("async_reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      #4 reset_n = 1'b1;
      repeat (40) @(negedge clock);
      start(32'd9, 32'd4, 32'd2, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
